// File: rtl/alu_pkg.sv
// alu_pkg: shared types and helpers for the multi-cycle execution unit.
//   alu_op_t     - 4-bit operation codes produced by the ALU decoder
//   exec_state_t - control states of alu_exec
//   add_ovf      - signed-overflow helper for two's-complement add
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD = 4'b0000,
        ALU_SUB = 4'b0001,
        ALU_AND = 4'b0010,
        ALU_OR  = 4'b0011,
        ALU_NOR = 4'b0100,
        ALU_XOR = 4'b0101,
        ALU_DIV = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_LSL = 4'b1000,
        ALU_LSR = 4'b1001
    } alu_op_t;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        DIV_RUN = 2'b01,
        DONE    = 2'b10
    } exec_state_t;

    // Overflow of a + b: both operands share a sign that the sum does not.
    // Subtraction reuses this by passing the inverted sign of b.
    function automatic logic add_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/alu_divider.sv
// alu_divider: iterative restoring unsigned divider, one quotient bit per step.
//   clk, reset          - clock, synchronous active-high reset
//   load                - capture dividend a / divisor b, clear remainder
//   step                - perform one shift/compare/subtract iteration
//   a, b                - dividend, divisor (sampled on load)
//   quo_next, rem_next  - quotient / remainder after the current step
//   last                - the current step is the final one (count hits 0)
module alu_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             step,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] quo_next,
    output logic [WIDTH-1:0] rem_next,
    output logic             last
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] quo_r;
    logic [WIDTH-1:0] rem_r;
    logic [WIDTH-1:0] div_r;
    logic [CW-1:0]    cnt_r;
    logic [WIDTH:0]   rem_sh_s;
    logic [WIDTH:0]   rem_sub_s;
    logic             ge_s;

    // One restoring iteration; the shifted remainder keeps an extra bit
    // because it can exceed WIDTH bits before the subtract.
    always_comb begin
        rem_sh_s  = {rem_r, quo_r[WIDTH-1]};
        rem_sub_s = rem_sh_s - {1'b0, div_r};
        ge_s      = (rem_sh_s >= {1'b0, div_r});
        if (ge_s) begin
            rem_next = rem_sub_s[WIDTH-1:0];
        end else begin
            rem_next = rem_sh_s[WIDTH-1:0];
        end
        quo_next = {quo_r[WIDTH-2:0], ge_s};
        last     = (cnt_r == CNT_ONE);
    end

    // Divider working registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            quo_r <= {WIDTH{1'b0}};
            rem_r <= {WIDTH{1'b0}};
            div_r <= {WIDTH{1'b0}};
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            quo_r <= a;
            rem_r <= {WIDTH{1'b0}};
            div_r <= b;
            cnt_r <= CNT_INIT;
        end else if (step) begin
            quo_r <= quo_next;
            rem_r <= rem_next;
            cnt_r <= cnt_r - CNT_ONE;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// alu_exec: execution unit for the decoded alucontrol code. Single-cycle ops
// complete one cycle after acceptance; DIV with non-zero divisor iterates for
// WIDTH cycles in alu_divider.
//   clk, reset      - clock, synchronous active-high reset
//   start           - request, accepted only while ready=1
//   alucontrol      - operation code (alu_op_t; other codes are illegal)
//   a, b            - operands / dividend, divisor / shift amount
//   ready, busy     - can accept start / division in progress
//   done            - one-cycle pulse, result and flags valid
//   result          - result or quotient
//   remainder       - DIV remainder, 0 otherwise
//   zero, overflow, dbz, illegal - status flags of the last completed op
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] remainder,
    output logic             zero,
    output logic             overflow,
    output logic             dbz,
    output logic             illegal
);

    exec_state_t      state_r;
    exec_state_t      state_nx_s;
    alu_op_t          op_s;
    logic             accept_s;
    logic             div_long_s;
    logic             cap_op_s;
    logic             div_load_s;
    logic             div_step_s;
    logic             div_fin_s;
    logic             div_last_s;
    logic [WIDTH-1:0] div_quo_s;
    logic [WIDTH-1:0] div_rem_s;
    logic [WIDTH-1:0] sum_s;
    logic [WIDTH-1:0] diff_s;
    logic [WIDTH-1:0] op_res_s;
    logic [WIDTH-1:0] op_rem_s;
    logic             op_ovf_s;
    logic             op_dbz_s;
    logic             op_ill_s;
    logic [WIDTH-1:0] result_r;
    logic [WIDTH-1:0] remainder_r;
    logic             zero_r;
    logic             overflow_r;
    logic             dbz_r;
    logic             illegal_r;

    alu_divider #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .reset    (reset),
        .load     (div_load_s),
        .step     (div_step_s),
        .a        (a),
        .b        (b),
        .quo_next (div_quo_s),
        .rem_next (div_rem_s),
        .last     (div_last_s)
    );

    // Single-cycle operation results; DIV by zero is resolved here too.
    always_comb begin
        op_s     = alu_op_t'(alucontrol);
        sum_s    = a + b;
        diff_s   = a - b;
        op_res_s = {WIDTH{1'b0}};
        op_rem_s = {WIDTH{1'b0}};
        op_ovf_s = 1'b0;
        op_dbz_s = 1'b0;
        op_ill_s = 1'b0;
        case (op_s)
            ALU_ADD: begin
                op_res_s = sum_s;
                op_ovf_s = add_ovf(a[WIDTH-1], b[WIDTH-1], sum_s[WIDTH-1]);
            end
            ALU_SUB: begin
                op_res_s = diff_s;
                op_ovf_s = add_ovf(a[WIDTH-1], ~b[WIDTH-1], diff_s[WIDTH-1]);
            end
            ALU_AND: op_res_s = a & b;
            ALU_OR:  op_res_s = a | b;
            ALU_NOR: op_res_s = ~(a | b);
            ALU_XOR: op_res_s = a ^ b;
            ALU_DIV: begin
                if (b == {WIDTH{1'b0}}) begin
                    op_res_s = {WIDTH{1'b1}};
                    op_rem_s = a;
                    op_dbz_s = 1'b1;
                end else begin
                    op_res_s = {WIDTH{1'b0}};
                end
            end
            ALU_SLT: op_res_s = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            // Logical shifts by an amount >= WIDTH already yield zero.
            ALU_LSL: op_res_s = a << b;
            ALU_LSR: op_res_s = a >> b;
            default: op_ill_s = 1'b1;
        endcase
    end

    // Next-state and control decode; DONE accepts a new start like IDLE.
    always_comb begin
        accept_s   = start && (state_r != DIV_RUN);
        div_long_s = (op_s == ALU_DIV) && (b != {WIDTH{1'b0}});
        state_nx_s = state_r;
        cap_op_s   = 1'b0;
        div_load_s = 1'b0;
        div_step_s = 1'b0;
        div_fin_s  = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (accept_s) begin
                    if (div_long_s) begin
                        div_load_s = 1'b1;
                        state_nx_s = DIV_RUN;
                    end else begin
                        cap_op_s   = 1'b1;
                        state_nx_s = DONE;
                    end
                end else begin
                    state_nx_s = IDLE;
                end
            end
            DIV_RUN: begin
                div_step_s = 1'b1;
                if (div_last_s) begin
                    div_fin_s  = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = DIV_RUN;
                end
            end
            default: state_nx_s = IDLE;
        endcase
    end

    // State register and result/flag registers; values hold between ops.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= IDLE;
            result_r    <= {WIDTH{1'b0}};
            remainder_r <= {WIDTH{1'b0}};
            zero_r      <= 1'b0;
            overflow_r  <= 1'b0;
            dbz_r       <= 1'b0;
            illegal_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            if (cap_op_s) begin
                result_r    <= op_res_s;
                remainder_r <= op_rem_s;
                zero_r      <= (op_res_s == {WIDTH{1'b0}});
                overflow_r  <= op_ovf_s;
                dbz_r       <= op_dbz_s;
                illegal_r   <= op_ill_s;
            end else if (div_fin_s) begin
                result_r    <= div_quo_s;
                remainder_r <= div_rem_s;
                zero_r      <= (div_quo_s == {WIDTH{1'b0}});
                overflow_r  <= 1'b0;
                dbz_r       <= 1'b0;
                illegal_r   <= 1'b0;
            end
        end
    end

    assign ready     = (state_r != DIV_RUN);
    assign busy      = (state_r == DIV_RUN);
    assign done      = (state_r == DONE);
    assign result    = result_r;
    assign remainder = remainder_r;
    assign zero      = zero_r;
    assign overflow  = overflow_r;
    assign dbz       = dbz_r;
    assign illegal   = illegal_r;

endmodule

// File: tb/tb_alu_exec.sv
// tb_alu_exec: directed and randomized self-checking bench for alu_exec.
module tb_alu_exec;

    localparam int W = 4;
    localparam int M = 1 << W;

    logic         clk;
    logic         reset;
    logic         start;
    logic [3:0]   alucontrol;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic [W-1:0] remainder;
    logic         zero;
    logic         overflow;
    logic         dbz;
    logic         illegal;

    int total = 0;
    int bad   = 0;

    alu_exec #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .ready      (ready),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .remainder  (remainder),
        .zero       (zero),
        .overflow   (overflow),
        .dbz        (dbz),
        .illegal    (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int to_signed(input int v);
        return (v >= M / 2) ? v - M : v;
    endfunction

    // Reference model straight from the arithmetic rules of each operation.
    function automatic void ref_op(input int op, input int av, input int bv,
                                   output int res, output int rem, output int ovf,
                                   output int dz, output int ill, output int lat);
        int t;
        res = 0; rem = 0; ovf = 0; dz = 0; ill = 0; lat = 1;
        case (op)
            0: begin
                t = to_signed(av) + to_signed(bv);
                res = (av + bv) % M;
                ovf = (t > M / 2 - 1 || t < -M / 2) ? 1 : 0;
            end
            1: begin
                t = to_signed(av) - to_signed(bv);
                res = (av - bv + M) % M;
                ovf = (t > M / 2 - 1 || t < -M / 2) ? 1 : 0;
            end
            2: res = av & bv;
            3: res = av | bv;
            4: res = (M - 1) - (av | bv);
            5: res = av ^ bv;
            6: begin
                if (bv == 0) begin
                    res = M - 1; rem = av; dz = 1;
                end else begin
                    res = av / bv; rem = av % bv; lat = W + 1;
                end
            end
            7: res = (to_signed(av) < to_signed(bv)) ? 1 : 0;
            8: res = (bv >= W) ? 0 : (av * (1 << bv)) % M;
            9: res = (bv >= W) ? 0 : av / (1 << bv);
            default: ill = 1;
        endcase
    endfunction

    task automatic chk_res(input string tag, input int op, input int av, input int bv);
        int res, rem, ovf, dz, ill, lat;
        ref_op(op, av, bv, res, rem, ovf, dz, ill, lat);
        chk({tag, "_done"},      done,      1);
        chk({tag, "_result"},    result,    res);
        chk({tag, "_remainder"}, remainder, rem);
        chk({tag, "_zero"},      zero,      (res == 0) ? 1 : 0);
        chk({tag, "_overflow"},  overflow,  ovf);
        chk({tag, "_dbz"},       dbz,       dz);
        chk({tag, "_illegal"},   illegal,   ill);
    endtask

    // Present one start for a single cycle, then scramble the operand bus.
    task automatic issue(input int op, input int av, input int bv);
        start      = 1'b1;
        alucontrol = op[3:0];
        a          = av[W-1:0];
        b          = bv[W-1:0];
        step();
        start      = 1'b0;
        a          = W'($urandom);
        b          = W'($urandom);
    endtask

    task automatic run_op(input string tag, input int op, input int av, input int bv);
        int res, rem, ovf, dz, ill, lat;
        int cyc;
        issue(op, av, bv);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            step();
            cyc++;
        end
        ref_op(op, av, bv, res, rem, ovf, dz, ill, lat);
        chk({tag, "_latency"}, cyc, lat);
        chk_res(tag, op, av, bv);
    endtask

    initial begin
        int seen;
        int op, av, bv;
        reset      = 1'b1;
        start      = 1'b0;
        alucontrol = 4'b0000;
        a          = {W{1'b0}};
        b          = {W{1'b0}};
        step();
        step();
        chk("rst_ready", ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_result", result, 0);
        chk("rst_remainder", remainder, 0);
        chk("rst_flags", {zero, overflow, dbz, illegal}, 0);
        reset = 1'b0;
        step();

        // ADD with signed overflow
        chk("add_ready_pre", ready, 1);
        issue(0, 7, 1);
        chk_res("add", 0, 7, 1);
        chk("add_ready_done", ready, 1);

        // SUB then AND started in the DONE cycle
        issue(1, 5, 5);
        chk_res("sub", 1, 5, 5);
        issue(2, 12, 10);
        chk_res("and_b2b", 2, 12, 10);
        step();
        chk("and_idle_done", done, 0);
        chk("and_hold_result", result, 8);

        // DIV 13/3 with an ignored start while busy
        issue(6, 13, 3);
        chk("div_busy1", busy, 1);
        chk("div_ready1", ready, 0);
        chk("div_done1", done, 0);
        step();
        start = 1'b1; alucontrol = 4'b0000; a = 4'd1; b = 4'd1;
        step();
        start = 1'b0;
        chk("div_busy3", busy, 1);
        step();
        chk("div_busy4", busy, 1);
        step();
        chk_res("div13_3", 6, 13, 3);
        step();
        chk("div_no_queue", done, 0);

        // DIV by zero, SLT, shifts, illegal
        run_op("div_by0", 6, 9, 0);
        run_op("slt", 7, 14, 1);
        run_op("lsl", 8, 3, 2);
        run_op("lsr", 9, 15, 5);
        run_op("illegal", 11, 6, 3);

        // Reset in the middle of a division
        issue(6, 13, 3);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_ready", ready, 1);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_remainder", remainder, 0);
        chk("mid_rst_flags", {zero, overflow, dbz, illegal}, 0);
        seen = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) seen++;
        end
        chk("mid_rst_no_done", seen, 0);

        // Randomized operations against the reference model
        for (int i = 0; i < 60; i++) begin
            op = $urandom_range(0, 15);
            av = $urandom_range(0, M - 1);
            bv = $urandom_range(0, M - 1);
            if (op == 6 && $urandom_range(0, 3) == 0) bv = 0;
            run_op("rand", op, av, bv);
            if ($urandom_range(0, 1) == 1) step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
